multiplier_arbiter_tainttrack1bit: RTL and testbench

MULTIPLIER_ARBITER_TAINTTRACK1BIT -- requirements
Module: multiplier_arbiter_tainttrack1bit

---
 rtl/multiplier_arbiter_tainttrack1bit.sv | 199 +++++++++++++++++++
 tb/tb_multiplier_arbiter_tainttrack1bit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_arbiter_tainttrack1bit.sv
// Two-requester round-robin front end for a shared multi-cycle multiplier, with 1-bit taint tracking.
// Define MULT_ARB_WATCHDOG_EN to add a WAIT-state watchdog that answers with rsp_err after WDOG_CYCLES.
module multiplier_arbiter_tainttrack1bit #(
  parameter int WIDTH       = 1024,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  input  logic                 req_valid_t,
  output logic [1:0]           req_ready,
  input  logic [WIDTH-1:0]     op_a0,
  input  logic [WIDTH-1:0]     op_b0,
  input  logic [WIDTH-1:0]     op_a1,
  input  logic [WIDTH-1:0]     op_b1,
  input  logic                 op_t0,
  input  logic                 op_t1,
  output logic                 mul_start,
  output logic                 mul_start_t,
  output logic [WIDTH-1:0]     mul_multiplier,
  output logic [WIDTH-1:0]     mul_multiplicand,
  output logic                 mul_multiplier_t,
  output logic                 mul_multiplicand_t,
  input  logic [2*WIDTH-1:0]   mul_product,
  input  logic                 mul_product_t,
  input  logic                 mul_done,
  input  logic                 mul_done_t,
  output logic                 rsp_valid,
  output logic                 rsp_valid_t,
  output logic                 rsp_id,
  output logic                 rsp_id_t,
  output logic [2*WIDTH-1:0]   rsp_product,
  output logic                 rsp_product_t,
  input  logic                 rsp_ready,
  output logic                 rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic                 gnt_q, gnt_d;
  logic                 gnt_t_q, gnt_t_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 op_t_q, op_t_d;
  logic                 first_q, first_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 prod_t_q, prod_t_d;
  logic                 done_t_q, done_t_d;
`ifdef MULT_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES) + 1;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
`endif

  logic req_any;
  logic grant_id;
  logic busy;
  logic in_resp;

  // With both requesters asking, the one not served last wins.
  assign req_any  = |req_valid;
  assign grant_id = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  assign req_ready = (state_q == IDLE && req_any && !rst) ?
                     (grant_id ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    gnt_t_d  = gnt_t_q;
    a_d      = a_q;
    b_d      = b_q;
    op_t_d   = op_t_q;
    first_d  = first_q;
    prod_d   = prod_q;
    prod_t_d = prod_t_q;
    done_t_d = done_t_q;
`ifdef MULT_ARB_WATCHDOG_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_any) begin
          gnt_d   = grant_id;
          gnt_t_d = req_valid_t;
          a_d     = grant_id ? op_a1 : op_a0;
          b_d     = grant_id ? op_b1 : op_b0;
          op_t_d  = (grant_id ? op_t1 : op_t0) | req_valid_t;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        first_d = 1'b1;
        state_d = WAIT;
`ifdef MULT_ARB_WATCHDOG_EN
        cnt_d   = '0;
        err_d   = 1'b0;
`endif
      end
      WAIT: begin
        // The first WAIT cycle may still see a stale done level from the previous job.
        first_d = 1'b0;
        if (!first_q && mul_done) begin
          prod_d   = mul_product;
          prod_t_d = mul_product_t;
          done_t_d = mul_done_t;
          state_d  = RESP;
        end
`ifdef MULT_ARB_WATCHDOG_EN
        else if (cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
          prod_d   = '0;
          prod_t_d = 1'b0;
          done_t_d = 1'b0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_d  = IDLE;
          last_d   = gnt_q;
          gnt_t_d  = 1'b0;
          op_t_d   = 1'b0;
          prod_t_d = 1'b0;
          done_t_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      gnt_t_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_t_q   <= 1'b0;
      first_q  <= 1'b0;
      prod_q   <= '0;
      prod_t_q <= 1'b0;
      done_t_q <= 1'b0;
`ifdef MULT_ARB_WATCHDOG_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      gnt_t_q  <= gnt_t_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_t_q   <= op_t_d;
      first_q  <= first_d;
      prod_q   <= prod_d;
      prod_t_q <= prod_t_d;
      done_t_q <= done_t_d;
`ifdef MULT_ARB_WATCHDOG_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // All outputs decode from registered state, so IDLE forces data and taint to 0.
  assign busy    = (state_q != IDLE);
  assign in_resp = (state_q == RESP);

  assign mul_start          = (state_q == ISSUE);
  assign mul_start_t        = (state_q == ISSUE) ? gnt_t_q : 1'b0;
  assign mul_multiplier     = busy ? a_q : '0;
  assign mul_multiplicand   = busy ? b_q : '0;
  assign mul_multiplier_t   = busy ? op_t_q : 1'b0;
  assign mul_multiplicand_t = busy ? op_t_q : 1'b0;

  assign rsp_valid     = in_resp;
  assign rsp_valid_t   = in_resp ? (gnt_t_q | done_t_q) : 1'b0;
  assign rsp_id        = in_resp ? gnt_q : 1'b0;
  assign rsp_id_t      = busy ? gnt_t_q : 1'b0;
  assign rsp_product   = in_resp ? prod_q : '0;
  assign rsp_product_t = in_resp ? (prod_t_q | gnt_t_q) : 1'b0;

`ifdef MULT_ARB_WATCHDOG_EN
  assign rsp_err = in_resp ? err_q : 1'b0;
`else
  // Always 0; the comparison keeps WDOG_CYCLES referenced in builds without the watchdog.
  assign rsp_err = (WDOG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_multiplier_arbiter_tainttrack1bit.sv
// Self-checking bench for multiplier_arbiter_tainttrack1bit (WIDTH=16, WDOG_CYCLES=8).
// Define MULT_ARB_WATCHDOG_EN for both RTL and bench to exercise the watchdog timeout path.
module tb_multiplier_arbiter_tainttrack1bit;

  localparam int W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic            req_valid_t;
  logic [1:0]      req_ready;
  logic [W-1:0]    op_a0, op_b0, op_a1, op_b1;
  logic            op_t0, op_t1;
  logic            mul_start, mul_start_t;
  logic [W-1:0]    mul_multiplier, mul_multiplicand;
  logic            mul_multiplier_t, mul_multiplicand_t;
  logic [2*W-1:0]  mul_product;
  logic            mul_product_t, mul_done, mul_done_t;
  logic            rsp_valid, rsp_valid_t, rsp_id, rsp_id_t;
  logic [2*W-1:0]  rsp_product;
  logic            rsp_product_t, rsp_ready, rsp_err;

  multiplier_arbiter_tainttrack1bit #(.WIDTH(W), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_valid_t(req_valid_t), .req_ready(req_ready),
    .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
    .op_t0(op_t0), .op_t1(op_t1),
    .mul_start(mul_start), .mul_start_t(mul_start_t),
    .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_multiplier_t(mul_multiplier_t), .mul_multiplicand_t(mul_multiplicand_t),
    .mul_product(mul_product), .mul_product_t(mul_product_t),
    .mul_done(mul_done), .mul_done_t(mul_done_t),
    .rsp_valid(rsp_valid), .rsp_valid_t(rsp_valid_t), .rsp_id(rsp_id), .rsp_id_t(rsp_id_t),
    .rsp_product(rsp_product), .rsp_product_t(rsp_product_t),
    .rsp_ready(rsp_ready), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   rv;
    logic [W-1:0] a0, b0, a1, b1;
    logic         t0, t1, rv_t, prod_t, done_t;
    logic         hold;
    int           delay;
    int           stall;
  } vec_t;

  typedef struct {
    logic         id;
    logic [2*W-1:0] prod;
    logic         id_t, prod_t, valid_t;
  } exp_t;

  exp_t sb[$];
  logic model_last;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic [1:0] rv, input int a0, input int b0, input int a1,
                                 input int b1, input logic t0, input logic t1, input logic rv_t,
                                 input logic prod_t, input logic done_t, input logic hold,
                                 input int delay, input int stall);
    vec_t v;
    v.rv = rv; v.a0 = W'(a0); v.b0 = W'(b0); v.a1 = W'(a1); v.b1 = W'(b1);
    v.t0 = t0; v.t1 = t1; v.rv_t = rv_t; v.prod_t = prod_t; v.done_t = done_t;
    v.hold = hold; v.delay = delay; v.stall = stall;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req_valid = v.rv; req_valid_t = v.rv_t;
    op_a0 = v.a0; op_b0 = v.b0; op_a1 = v.a1; op_b1 = v.b1;
    op_t0 = v.t0; op_t1 = v.t1;
    rsp_ready = 1'b0; mul_done = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".req_ready"}, 64'(req_ready), 64'(0));
    checkOutput({tag, ".mul_start"}, 64'(mul_start), 64'(0));
    checkOutput({tag, ".operands"}, 64'({mul_multiplier, mul_multiplicand}), 64'(0));
    checkOutput({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(0));
    checkOutput({tag, ".rsp_id"}, 64'(rsp_id), 64'(0));
    checkOutput({tag, ".rsp_product"}, 64'(rsp_product), 64'(0));
    checkOutput({tag, ".rsp_err"}, 64'(rsp_err), 64'(0));
    checkOutput({tag, ".taints"}, 64'({mul_start_t, mul_multiplier_t, mul_multiplicand_t,
                                       rsp_valid_t, rsp_id_t, rsp_product_t}), 64'(0));
  endtask

  // One full transaction from an IDLE grant cycle through the accepting RESP cycle.
  task automatic doTxn(input vec_t v);
    logic id;
    logic [W-1:0] ea, eb;
    logic mt;
    exp_t e, got;
    id = (v.rv == 2'b11) ? ~model_last : v.rv[1];
    ea = id ? v.a1 : v.a0;
    eb = id ? v.b1 : v.b0;
    mt = (id ? v.t1 : v.t0) | v.rv_t;
    e.id = id; e.prod = 32'(ea) * 32'(eb);
    e.id_t = v.rv_t; e.prod_t = v.prod_t | v.rv_t; e.valid_t = v.rv_t | v.done_t;

    @(negedge clk); applyStimulus(v); #1;
    checkOutput("grant.req_ready", 64'(req_ready), id ? 64'(2) : 64'(1));
    sb.push_back(e);

    @(negedge clk);
    if (!v.hold) req_valid = v.rv & ~(id ? 2'b10 : 2'b01);
    #1;
    checkOutput("issue.req_ready", 64'(req_ready), 64'(0));
    checkOutput("issue.mul_start", 64'(mul_start), 64'(1));
    checkOutput("issue.mul_start_t", 64'(mul_start_t), 64'(v.rv_t));
    checkOutput("issue.mul_multiplier", 64'(mul_multiplier), 64'(ea));
    checkOutput("issue.mul_multiplicand", 64'(mul_multiplicand), 64'(eb));
    checkOutput("issue.operand_t", 64'({mul_multiplier_t, mul_multiplicand_t}), 64'({mt, mt}));

    for (int k = 1; k <= v.delay; k++) begin
      @(negedge clk);
      if (k == v.delay) begin
        mul_done = 1'b1; mul_product = 32'(mul_multiplier) * 32'(mul_multiplicand);
        mul_product_t = v.prod_t; mul_done_t = v.done_t;
      end else if (k == 1) begin
        mul_done = 1'b1; mul_product = 32'hDEADBEEF; mul_product_t = 1'b1; mul_done_t = 1'b1;
      end else begin
        mul_done = 1'b0;
      end
      #1;
      checkOutput("wait.mul_start", 64'(mul_start), 64'(0));
      checkOutput("wait.rsp_valid", 64'(rsp_valid), 64'(0));
      checkOutput("wait.mul_multiplier", 64'(mul_multiplier), 64'(ea));
    end

    @(negedge clk);
    mul_done = 1'b0; mul_product = '0; mul_product_t = 1'b0; mul_done_t = 1'b0;
    #1;
    checkOutput("resp.rsp_valid", 64'(rsp_valid), 64'(1));
    if (sb.size() == 0) begin
      checkOutput("resp.scoreboard_nonempty", 64'(0), 64'(1));
    end else begin
      got = sb.pop_front();
      checkOutput("resp.rsp_id", 64'(rsp_id), 64'(got.id));
      checkOutput("resp.rsp_product", 64'(rsp_product), 64'(got.prod));
      checkOutput("resp.rsp_id_t", 64'(rsp_id_t), 64'(got.id_t));
      checkOutput("resp.rsp_product_t", 64'(rsp_product_t), 64'(got.prod_t));
      checkOutput("resp.rsp_valid_t", 64'(rsp_valid_t), 64'(got.valid_t));
      checkOutput("resp.rsp_err", 64'(rsp_err), 64'(0));
      for (int s = 0; s < v.stall; s++) begin
        @(negedge clk); #1;
        checkOutput("stall.rsp_hold", 64'({rsp_valid, rsp_id, rsp_product}),
                    64'({1'b1, got.id, got.prod}));
        checkOutput("stall.no_grant", 64'({req_ready, mul_start}), 64'(0));
      end
    end
    @(negedge clk); rsp_ready = 1'b1; #1;
    checkOutput("accept.rsp_valid", 64'(rsp_valid), 64'(1));
    model_last = id;
  endtask

  task automatic idleCycle(input string tag);
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 2'b00; req_valid_t = 1'b0; mul_done = 1'b0;
    #1;
    checkResetValues(tag);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    vecs[0] = mkVec(2'b01, 3, 5, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 10);
    vecs[1] = mkVec(2'b10, 0, 0, 7, 9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
    vecs[2] = mkVec(2'b10, 1, 1, 100, 200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1);
    vecs[3] = mkVec(2'b01, 16'hFFFF, 16'hFFFF, 5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 2);

    rst = 1'b1; req_valid = 2'b11; req_valid_t = 1'b1;
    op_a0 = '0; op_b0 = '0; op_a1 = '0; op_b1 = '0; op_t0 = 1'b1; op_t1 = 1'b1;
    mul_product = '0; mul_product_t = 1'b0; mul_done = 1'b0; mul_done_t = 1'b0; rsp_ready = 1'b0;
    model_last = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk); rst = 1'b0; req_valid = 2'b00; req_valid_t = 1'b0; op_t0 = 1'b0; op_t1 = 1'b0;

    for (int i = 0; i < 4; i++) doTxn(vecs[i]);
    idleCycle("idle_after_table");

    // Reset while waiting on the multiplier, followed by a late done.
    @(negedge clk);
    req_valid = 2'b01; req_valid_t = 1'b1; op_t0 = 1'b1; op_a0 = 16'd9; op_b0 = 16'd9;
    #1;
    checkOutput("rstwait.req_ready", 64'(req_ready), 64'(1));
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mul_done = 1'b1; mul_product = 32'd81; mul_product_t = 1'b1; mul_done_t = 1'b1;
    #1;
    checkResetValues("rstwait");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checkOutput("rstwait.late_done_ignored", 64'({rsp_valid, mul_start}), 64'(0));
    end
    @(negedge clk); mul_done = 1'b0; mul_product = '0; mul_product_t = 1'b0; mul_done_t = 1'b0;
    req_valid_t = 1'b0; op_t0 = 1'b0;
    model_last = 1'b1;

    // Both requesters held valid: grants must alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      doTxn(mkVec(2'b11, 10 + i, 3, 20 + i, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2 + i, i));
      checkOutput("contention.order", 64'(model_last), 64'(i % 2));
    end
    idleCycle("idle_after_contention");

    // Multiplier that never answers.
    @(negedge clk);
    req_valid = 2'b01; req_valid_t = 1'b1; op_a0 = 16'd4; op_b0 = 16'd4;
    @(negedge clk); req_valid = 2'b00; #1;
    checkOutput("wdog.mul_start", 64'(mul_start), 64'(1));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      checkOutput("wdog.wait_rsp_valid", 64'(rsp_valid), 64'(0));
    end
`ifdef MULT_ARB_WATCHDOG_EN
    @(negedge clk); #1;
    checkOutput("wdog.rsp_valid", 64'(rsp_valid), 64'(1));
    checkOutput("wdog.rsp_err", 64'(rsp_err), 64'(1));
    checkOutput("wdog.rsp_product", 64'(rsp_product), 64'(0));
    checkOutput("wdog.rsp_product_t", 64'(rsp_product_t), 64'(1));
    @(negedge clk); rsp_ready = 1'b1;
    idleCycle("idle_after_wdog");
`else
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      checkOutput("nowdog.rsp_valid", 64'({rsp_valid, rsp_err}), 64'(0));
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; req_valid_t = 1'b0; #1;
    checkResetValues("nowdog_reset");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
